// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side bus bundle for the
// unified-memory port arbiter. The slave modport is the arbiter's view and
// the master modport is the requesters'/memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-ported unified memory between the fetch
// port and the load/store port. Data has priority; read data returns one
// cycle after the grant. Once the pipeline halts, fetch service stops and
// outstanding reads drain.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN to let fetch win
// after MAX_DATA_RUN consecutive data grants taken while fetch was waiting.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                clk1,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    input  logic                halted,
    output logic                stall_if,
    output logic [1:0]          arb_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D_RD = 2'b10
    } owner_t;

    generate
        if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_bad_run
            $error("MAX_DATA_RUN must be in 1..15");
        end
    endgenerate

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              if_gnt, d_gnt, fetch_wins;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [DATA_W-1:0] if_rdata_mux, d_rdata_mux;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] run_q;

    // Count data grants taken while fetch waits; any fetch grant or fetch
    // going idle restarts the run. Only meaningful while running.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            run_q <= 4'd0;
        else if (state_q != ST_RUN || if_gnt || !bus.if_req)
            run_q <= 4'd0;
        else if (d_gnt && run_q != 4'hF)
            run_q <= run_q + 4'd1;
    end

    assign fetch_wins = (state_q == ST_RUN) && !halted && bus.if_req && bus.d_req
                        && (run_q == 4'(MAX_DATA_RUN));
`else
    assign fetch_wins = 1'b0;
`endif

    // Grant: data first (older instruction), fetch only while running and not
    // halting. Everything is forced low while reset is held.
    always_comb begin
        d_gnt  = rst_n && bus.d_req && !fetch_wins;
        if_gnt = rst_n && bus.if_req && (state_q == ST_RUN) && !halted
                 && (!bus.d_req || fetch_wins);
    end

    // Memory-side mux from whichever port holds the grant.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (d_gnt) begin
            addr_mux = bus.d_addr;
            if (bus.d_we) wdata_mux = bus.d_wdata;
        end else if (if_gnt) begin
            addr_mux = bus.if_addr;
        end
    end

    // Remember which port owns the read data arriving next cycle; stores
    // complete at the edge and produce no return.
    always_comb begin
        owner_d = OWN_NONE;
        if (d_gnt && !bus.d_we) owner_d = OWN_D_RD;
        else if (if_gnt)        owner_d = OWN_IF;
    end

    // Run/drain/halt sequencing; HALTED is only left through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halted) state_d = (owner_q == OWN_NONE) ? ST_HALTED : ST_DRAIN;
            ST_DRAIN:  if (owner_q == OWN_NONE) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // State and owner registers; reset drops any in-flight return.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Return path: pass memory data only to the owning port.
    always_comb begin
        if_rdata_mux = (owner_q == OWN_IF)   ? bus.mem_rdata : '0;
        d_rdata_mux  = (owner_q == OWN_D_RD) ? bus.mem_rdata : '0;
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.d_rvalid  = (owner_q == OWN_D_RD);
    assign bus.if_rdata  = if_rdata_mux;
    assign bus.d_rdata   = d_rdata_mux;
    assign bus.mem_en    = if_gnt | d_gnt;
    assign bus.mem_we    = d_gnt & bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign stall_if      = rst_n & bus.if_req & ~if_gnt;
    assign arb_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table for single-cycle behaviour plus
// hand sequences for reset, reset during a read, and starvation.
module tb_mem_port_arbiter;

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic       halted;
    logic       stall_if;
    logic [1:0] arb_state;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .halted    (halted),
        .stall_if  (stall_if),
        .arb_state (arb_state)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        halted;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_if_rv;
        logic [31:0] e_if_rd;
        logic        e_d_rv;
        logic [31:0] e_d_rd;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [1:0]  e_state;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Inputs: if_req if_addr d_req d_we d_addr d_wdata halted mem_rdata
        // Expect: if_gnt d_gnt if_rv if_rd d_rv d_rd mem_we mem_addr mem_wdata stall state
        vt[0]  = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,  32'h0,    1'b0, 2'b00};
        vt[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h28010078, 1'b0, 1'b0, 1'b1, 32'h28010078, 1'b0, 32'h0,    1'b0, 32'h0,  32'h0,    1'b0, 2'b00};
        vt[2]  = '{1'b1, 32'h4,  1'b1, 1'b0, 32'h78, 32'h0,    1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h78, 32'h0,    1'b1, 2'b00};
        vt[3]  = '{1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h63,       1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h63,   1'b0, 32'h4,  32'h0,    1'b0, 2'b00};
        vt[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h1234,     1'b0, 1'b0, 1'b1, 32'h1234,     1'b0, 32'h0,    1'b0, 32'h0,  32'h0,    1'b0, 2'b00};
        vt[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h79, 32'hABCD, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 32'h79, 32'hABCD, 1'b0, 2'b00};
        vt[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h7,  32'h0,    1'b0, 32'h5555,     1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h7,  32'h0,    1'b0, 2'b00};
        vt[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h8,  32'h0,    1'b0, 32'h77,       1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h77,   1'b0, 32'h8,  32'h0,    1'b0, 2'b00};
        vt[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h88,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h88,   1'b0, 32'h0,  32'h0,    1'b0, 2'b00};
        vt[9]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h10, 32'h0,    1'b0, 2'b00};
        vt[10] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 32'h99,       1'b0, 1'b0, 1'b1, 32'h99,       1'b0, 32'h0,    1'b0, 32'h0,  32'h0,    1'b1, 2'b00};
        vt[11] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,  32'h0,    1'b1, 2'b01};
        vt[12] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,  32'h0,    1'b1, 2'b10};
        vt[13] = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h79, 32'h5,    1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 32'h79, 32'h5,    1'b1, 2'b10};
        vt[14] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h9,  32'h0,    1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h9,  32'h0,    1'b1, 2'b10};
        vt[15] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h42,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h42,   1'b0, 32'h0,  32'h0,    1'b1, 2'b10};

        // Reset held with both requests high: everything must read zero.
        rst_n = 1'b0; halted = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h66;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h55; bus.d_wdata = 32'h0;
        bus.mem_rdata = 32'hDEAD;
        repeat (2) @(negedge clk1);
        chk("rst if_gnt",    64'(bus.if_gnt),    64'h0);
        chk("rst d_gnt",     64'(bus.d_gnt),     64'h0);
        chk("rst if_rvalid", 64'(bus.if_rvalid), 64'h0);
        chk("rst d_rvalid",  64'(bus.d_rvalid),  64'h0);
        chk("rst if_rdata",  64'(bus.if_rdata),  64'h0);
        chk("rst d_rdata",   64'(bus.d_rdata),   64'h0);
        chk("rst mem_en",    64'(bus.mem_en),    64'h0);
        chk("rst mem_we",    64'(bus.mem_we),    64'h0);
        chk("rst mem_addr",  64'(bus.mem_addr),  64'h0);
        chk("rst mem_wdata", 64'(bus.mem_wdata), 64'h0);
        chk("rst stall_if",  64'(stall_if),      64'h0);
        chk("rst arb_state", 64'(arb_state),     64'h0);

        // First cycle after release: data wins immediately.
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk1);
        chk("rel d_gnt",    64'(bus.d_gnt),    64'h1);
        chk("rel if_gnt",   64'(bus.if_gnt),   64'h0);
        chk("rel stall_if", 64'(stall_if),     64'h1);
        chk("rel mem_addr", 64'(bus.mem_addr), 64'h55);
        next_cycle();
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk1);
        chk("rel d_rvalid", 64'(bus.d_rvalid), 64'h1);
        chk("rel d_rdata",  64'(bus.d_rdata),  64'hDEAD);

        // Vector table: one record per cycle, state carries between records.
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            bus.if_req = vt[i].if_req; bus.if_addr = vt[i].if_addr;
            bus.d_req = vt[i].d_req; bus.d_we = vt[i].d_we;
            bus.d_addr = vt[i].d_addr; bus.d_wdata = vt[i].d_wdata;
            halted = vt[i].halted; bus.mem_rdata = vt[i].mem_rdata;
            @(negedge clk1);
            chk($sformatf("v%0d if_gnt", i),    64'(bus.if_gnt),    64'(vt[i].e_if_gnt));
            chk($sformatf("v%0d d_gnt", i),     64'(bus.d_gnt),     64'(vt[i].e_d_gnt));
            chk($sformatf("v%0d mem_en", i),    64'(bus.mem_en),    64'(vt[i].e_if_gnt | vt[i].e_d_gnt));
            chk($sformatf("v%0d mem_we", i),    64'(bus.mem_we),    64'(vt[i].e_we));
            chk($sformatf("v%0d mem_addr", i),  64'(bus.mem_addr),  64'(vt[i].e_addr));
            chk($sformatf("v%0d mem_wdata", i), 64'(bus.mem_wdata), 64'(vt[i].e_wdata));
            chk($sformatf("v%0d if_rvalid", i), 64'(bus.if_rvalid), 64'(vt[i].e_if_rv));
            chk($sformatf("v%0d if_rdata", i),  64'(bus.if_rdata),  64'(vt[i].e_if_rd));
            chk($sformatf("v%0d d_rvalid", i),  64'(bus.d_rvalid),  64'(vt[i].e_d_rv));
            chk($sformatf("v%0d d_rdata", i),   64'(bus.d_rdata),   64'(vt[i].e_d_rd));
            chk($sformatf("v%0d stall_if", i),  64'(stall_if),      64'(vt[i].e_stall));
            chk($sformatf("v%0d arb_state", i), 64'(arb_state),     64'(vt[i].e_state));
        end

        // Reset out of HALTED, then reset landing while a load's data is due.
        next_cycle();
        rst_n = 1'b0; halted = 1'b0;
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_rdata = 32'h0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk1);
        chk("rst2 arb_state", 64'(arb_state), 64'h0);
        next_cycle();
        bus.d_req = 1'b1; bus.d_addr = 32'h3;
        @(negedge clk1);
        chk("midrd d_gnt", 64'(bus.d_gnt), 64'h1);
        next_cycle();
        rst_n = 1'b0; bus.d_req = 1'b0; bus.mem_rdata = 32'hBEEF;
        @(negedge clk1);
        chk("midrd d_rvalid in rst", 64'(bus.d_rvalid), 64'h0);
        chk("midrd d_rdata in rst",  64'(bus.d_rdata),  64'h0);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            chk($sformatf("midrd d_rvalid after %0d", k),  64'(bus.d_rvalid),  64'h0);
            chk($sformatf("midrd if_rvalid after %0d", k), 64'(bus.if_rvalid), 64'h0);
            next_cycle();
        end

        // Starvation: both ports hold their requests for 20 cycles.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        for (int k = 0; k < 20; k++) begin
            logic exp_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = ((k % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            @(negedge clk1);
            chk($sformatf("starve %0d if_gnt", k), 64'(bus.if_gnt), 64'(exp_if));
            chk($sformatf("starve %0d d_gnt", k),  64'(bus.d_gnt),  64'(!exp_if));
            next_cycle();
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
